// File: rtl/pll_mode_ctrl_if.sv
// pll_mode_ctrl_if
//   Bundles the mode-request, rPLL and status signals of pll_mode_ctrl.
//   The clock and the synchronous reset stay as plain ports on the controller.
//
//   Request protocol: mode_req is a single-cycle strobe that qualifies
//   mode_sel on the same clkin edge. There is no back-pressure. The controller
//   accepts every in-range request immediately. An out-of-range request is
//   dropped and answered with a one-cycle req_err pulse.
//
//   Signals
//     mode_sel  [2:0]  requested mode index           (master -> slave)
//     mode_req         request strobe                 (master -> slave)
//     pll_lock         rPLL LOCK, asynchronous        (master -> slave)
//     pll_reset        rPLL RESET                     (slave -> master)
//     idsel     [5:0]  rPLL IDSEL                     (slave -> master)
//     fbdsel    [5:0]  rPLL FBDSEL                    (slave -> master)
//     odsel     [5:0]  rPLL ODSEL                     (slave -> master)
//     mode_cur  [2:0]  mode currently programmed      (slave -> master)
//     busy             reset pulse or lock wait active
//     locked           filtered lock
//     fault            retries exhausted
//     req_err          one-cycle pulse on a rejected request
//     pix_rst          pixel-domain reset, equals ~locked
//     dbg_state [1:0]  controller FSM state, for observation only
interface pll_mode_ctrl_if;
  logic [2:0] mode_sel;
  logic       mode_req;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] idsel;
  logic [5:0] fbdsel;
  logic [5:0] odsel;
  logic [2:0] mode_cur;
  logic       busy;
  logic       locked;
  logic       fault;
  logic       req_err;
  logic       pix_rst;
  logic [1:0] dbg_state;

  modport master (
    output mode_sel, mode_req, pll_lock,
    input  pll_reset, idsel, fbdsel, odsel, mode_cur,
    input  busy, locked, fault, req_err, pix_rst, dbg_state
  );

  modport slave (
    input  mode_sel, mode_req, pll_lock,
    output pll_reset, idsel, fbdsel, odsel, mode_cur,
    output busy, locked, fault, req_err, pix_rst, dbg_state
  );
endinterface

// File: rtl/pll_mode_ctrl.sv
// pll_mode_ctrl
//   Supervisor and dynamic-reconfiguration controller for a Gowin rPLL that
//   has its dynamic divider selects enabled. The controller drives the rPLL
//   dividers from a table of up to 8 modes. It pulses the rPLL reset, filters
//   LOCK, and retries an attempt that times out. It holds the pixel domain in
//   reset until the clock is stable.
//
//   Ports
//     clkin   free-running crystal clock. This is the only clock domain.
//     reset   synchronous, active-high
//     ctrl    pll_mode_ctrl_if.slave, carrying the request, rPLL and status
//             signals
//
//   All outputs are registered. Each output register loads a value that is
//   decoded from the next state, so an output changes on the same edge as the
//   state transition that causes it.
module pll_mode_ctrl #(
  parameter int          NUM_MODES    = 2,
  parameter int          DEFAULT_MODE = 0,
  parameter logic [47:0] IDSEL_TABLE  = 48'h0,
  parameter logic [47:0] FBDSEL_TABLE = 48'h0,
  parameter logic [47:0] ODSEL_TABLE  = 48'h0,
  parameter int          RESET_PULSE  = 8,
  parameter int          LOCK_FILTER  = 16,
  parameter int          LOCK_TIMEOUT = 65535,
  parameter int          MAX_RETRIES  = 3
) (
  input logic            clkin,
  input logic            reset,
  pll_mode_ctrl_if.slave ctrl
);

  localparam int RP_W = $clog2(RESET_PULSE + 1);
  localparam int FL_W = $clog2(LOCK_FILTER + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int RT_W = $clog2(MAX_RETRIES + 1);
  localparam logic [FL_W-1:0] FL_MAX   = '1;
  localparam logic [TO_W-1:0] TO_MAX   = '1;
  localparam logic [RT_W-1:0] RT_MAX   = '1;
  localparam logic [2:0]      DEF_MODE = 3'(DEFAULT_MODE);

  typedef enum logic [1:0] {
    S_RST_PLL = 2'd0,
    S_WAIT    = 2'd1,
    S_LOCKED  = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  function automatic logic [5:0] pick(input logic [47:0] tbl, input logic [2:0] idx);
    pick = tbl[6*int'(idx) +: 6];
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      lock_sync_q;
  logic [RP_W-1:0] rcnt_q, rcnt_d;
  logic [FL_W-1:0] filt_q, filt_d;
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic [RT_W-1:0] retry_q, retry_d;
  logic [2:0]      mode_q, mode_d;

  logic pll_reset_q, pll_reset_d;
  logic busy_q, busy_d;
  logic locked_q, locked_d;
  logic fault_q, fault_d;
  logic req_err_q, req_err_d;
  logic pix_rst_q, pix_rst_d;
  logic [5:0] idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;

  logic lock_s;
  logic req_ok;

  assign lock_s = lock_sync_q[1];
  // The zero-extension lets NUM_MODES = 8 accept every 3-bit index.
  assign req_ok = ctrl.mode_req && ({1'b0, ctrl.mode_sel} < 4'(NUM_MODES));

  // State register, together with the lock synchronizer and the output
  // registers.
  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_sync_q <= '0;
      state_q     <= S_RST_PLL;
      rcnt_q      <= '0;
      filt_q      <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      mode_q      <= DEF_MODE;
      pll_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
      req_err_q   <= 1'b0;
      pix_rst_q   <= 1'b1;
      idsel_q     <= pick(IDSEL_TABLE, DEF_MODE);
      fbdsel_q    <= pick(FBDSEL_TABLE, DEF_MODE);
      odsel_q     <= pick(ODSEL_TABLE, DEF_MODE);
    end else begin
      lock_sync_q <= {lock_sync_q[0], ctrl.pll_lock};
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      filt_q      <= filt_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      mode_q      <= mode_d;
      pll_reset_q <= pll_reset_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
      req_err_q   <= req_err_d;
      pix_rst_q   <= pix_rst_d;
      idsel_q     <= idsel_d;
      fbdsel_q    <= fbdsel_d;
      odsel_q     <= odsel_d;
    end
  end

  // Next-state logic. An accepted request overrides every state.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    filt_d  = filt_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;
    mode_d  = mode_q;
    if (req_ok) begin
      state_d = S_RST_PLL;
      rcnt_d  = '0;
      filt_d  = '0;
      tmo_d   = '0;
      retry_d = '0;
      mode_d  = ctrl.mode_sel;
    end else begin
      case (state_q)
        S_RST_PLL: begin
          if (int'(rcnt_q) + 1 >= RESET_PULSE) begin
            state_d = S_WAIT;
            rcnt_d  = '0;
            filt_d  = '0;
            tmo_d   = '0;
          end else begin
            rcnt_d = rcnt_q + RP_W'(1);
          end
        end
        S_WAIT: begin
          filt_d = !lock_s ? '0 : (filt_q == FL_MAX) ? filt_q : filt_q + FL_W'(1);
          tmo_d  = (tmo_q == TO_MAX) ? tmo_q : tmo_q + TO_W'(1);
          // Filter completion is tested first, so a lock that completes on
          // the timeout cycle still counts as a lock.
          if (lock_s && (int'(filt_q) + 1 >= LOCK_FILTER)) begin
            state_d = S_LOCKED;
            retry_d = '0;
          end else if (int'(tmo_q) + 1 >= LOCK_TIMEOUT) begin
            retry_d = (retry_q == RT_MAX) ? retry_q : retry_q + RT_W'(1);
            rcnt_d  = '0;
            state_d = (int'(retry_q) + 1 >= MAX_RETRIES) ? S_FAULT : S_RST_PLL;
          end
        end
        S_LOCKED: begin
          // A loss of lock restarts the sequence. It does not count as a
          // failed attempt.
          if (!lock_s) begin
            state_d = S_RST_PLL;
            rcnt_d  = '0;
          end
        end
        default: ; // S_FAULT waits for a valid request
      endcase
    end
  end

  // Output decode from the next state. The dividers follow mode_d, and mode_d
  // only changes on an accepted request. That request also forces pll_reset
  // high on the same edge.
  always_comb begin
    pll_reset_d = (state_d == S_RST_PLL) || (state_d == S_FAULT);
    busy_d      = (state_d == S_RST_PLL) || (state_d == S_WAIT);
    locked_d    = (state_d == S_LOCKED);
    fault_d     = (state_d == S_FAULT);
    pix_rst_d   = (state_d != S_LOCKED);
    req_err_d   = ctrl.mode_req && !req_ok;
    idsel_d     = pick(IDSEL_TABLE, mode_d);
    fbdsel_d    = pick(FBDSEL_TABLE, mode_d);
    odsel_d     = pick(ODSEL_TABLE, mode_d);
  end

  assign ctrl.pll_reset = pll_reset_q;
  assign ctrl.busy      = busy_q;
  assign ctrl.locked    = locked_q;
  assign ctrl.fault     = fault_q;
  assign ctrl.req_err   = req_err_q;
  assign ctrl.pix_rst   = pix_rst_q;
  assign ctrl.idsel     = idsel_q;
  assign ctrl.fbdsel    = fbdsel_q;
  assign ctrl.odsel     = odsel_q;
  assign ctrl.mode_cur  = mode_q;
  assign ctrl.dbg_state = state_q;

endmodule

// File: tb/tb_pll_mode_ctrl.sv
`timescale 1ns/1ps
module tb_pll_mode_ctrl;
  localparam int NUM_MODES    = 2;
  localparam int DEFAULT_MODE = 0;
  localparam int RESET_PULSE  = 8;
  localparam int LOCK_FILTER  = 16;
  localparam int LOCK_TIMEOUT = 100;
  localparam int MAX_RETRIES  = 3;
  localparam logic [47:0] T_ID = {36'd0, 6'd5,  6'd3};
  localparam logic [47:0] T_FB = {36'd0, 6'd41, 6'd20};
  localparam logic [47:0] T_OD = {36'd0, 6'd60, 6'd56};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_mode_ctrl_if bus();

  pll_mode_ctrl #(
    .NUM_MODES(NUM_MODES), .DEFAULT_MODE(DEFAULT_MODE),
    .IDSEL_TABLE(T_ID), .FBDSEL_TABLE(T_FB), .ODSEL_TABLE(T_OD),
    .RESET_PULSE(RESET_PULSE), .LOCK_FILTER(LOCK_FILTER),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .clkin(clk),
    .reset(rst),
    .ctrl(bus)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // The model describes the controller as phases. The reset pulse counts
  // down the cycles it has left. The lock wait counts consecutive lock
  // samples and the cycles it has waited. The lock synchronizer is modelled
  // as a two-sample delay line.
  localparam int PH_PULSE = 0, PH_WAIT = 1, PH_UP = 2, PH_FAULT = 3;
  int m_phase = PH_PULSE, m_left = RESET_PULSE, m_run = 0, m_waited = 0, m_fails = 0;
  int m_mode = DEFAULT_MODE;
  bit m_req_err = 1'b0, m_s0 = 1'b0, m_s1 = 1'b0;

  always @(posedge clk) begin
    bit ls;
    ls = m_s1; m_s1 = m_s0; m_s0 = bus.pll_lock;
    if (rst) begin
      m_s0 = 1'b0; m_s1 = 1'b0;
      m_phase = PH_PULSE; m_left = RESET_PULSE; m_run = 0; m_waited = 0;
      m_fails = 0; m_mode = DEFAULT_MODE; m_req_err = 1'b0;
    end else begin
      m_req_err = 1'b0;
      if (bus.mode_req && bus.mode_sel < NUM_MODES) begin
        m_mode = bus.mode_sel; m_phase = PH_PULSE; m_left = RESET_PULSE; m_fails = 0;
      end else begin
        if (bus.mode_req) m_req_err = 1'b1;
        case (m_phase)
          PH_PULSE: begin
            m_left--;
            if (m_left == 0) begin m_phase = PH_WAIT; m_run = 0; m_waited = 0; end
          end
          PH_WAIT: begin
            m_run = ls ? m_run + 1 : 0;
            m_waited++;
            if (m_run >= LOCK_FILTER) begin
              m_phase = PH_UP; m_fails = 0;
            end else if (m_waited >= LOCK_TIMEOUT) begin
              m_fails++;
              if (m_fails >= MAX_RETRIES) m_phase = PH_FAULT;
              else begin m_phase = PH_PULSE; m_left = RESET_PULSE; end
            end
          end
          PH_UP: if (!ls) begin m_phase = PH_PULSE; m_left = RESET_PULSE; end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [26:0] exp_vec();
    exp_vec = {(m_phase == PH_PULSE) || (m_phase == PH_FAULT),
               (m_phase == PH_PULSE) || (m_phase == PH_WAIT),
               m_phase == PH_UP, m_phase == PH_FAULT, m_req_err, m_phase != PH_UP,
               3'(m_mode), T_ID[6*m_mode +: 6], T_FB[6*m_mode +: 6], T_OD[6*m_mode +: 6]};
  endfunction

  function automatic logic [26:0] dut_vec();
    dut_vec = {bus.pll_reset, bus.busy, bus.locked, bus.fault, bus.req_err, bus.pix_rst,
               bus.mode_cur, bus.idsel, bus.fbdsel, bus.odsel};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic request(input logic [2:0] sel);
    bus.mode_sel = sel;
    bus.mode_req = 1'b1;
    step();
    bus.mode_req = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; bus.pll_lock = 1'b0; bus.mode_sel = 3'd1; bus.mode_req = 1'b1;
    repeat (3) step();
    bus.mode_req = 1'b0;
    step();
    checks++;
    if ({bus.pll_reset, bus.busy, bus.locked, bus.fault, bus.req_err, bus.pix_rst} !== 6'b110001) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=110001",
               {bus.pll_reset, bus.busy, bus.locked, bus.fault, bus.req_err, bus.pix_rst});
    end
    checks++;
    if (bus.mode_cur !== 3'd0) begin
      failures++; $display("FAIL reset_mode got=%0d exp=0", bus.mode_cur);
    end
    checks++;
    if ({bus.idsel, bus.fbdsel, bus.odsel} !== {6'd3, 6'd20, 6'd56}) begin
      failures++;
      $display("FAIL reset_div got=%0d/%0d/%0d exp=3/20/56", bus.idsel, bus.fbdsel, bus.odsel);
    end
  endtask

  task automatic test_power_up();
    int n;
    rst = 1'b0;
    n = 0;
    while (bus.pll_reset === 1'b1 && n < 50) begin
      n++;
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL pwr_model got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    checks++;
    if (n != RESET_PULSE) begin
      failures++; $display("FAIL pwr_pulse_len got=%0d exp=%0d", n, RESET_PULSE);
    end
    bus.pll_lock = 1'b1;
    n = 0;
    while (bus.locked !== 1'b1 && n < 100) begin
      step(); n++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL pwr_lock_model got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    checks++;
    if (n != 2 + LOCK_FILTER) begin
      failures++; $display("FAIL pwr_lock_latency got=%0d exp=%0d", n, 2 + LOCK_FILTER);
    end
    checks++;
    if ({bus.pix_rst, bus.busy, bus.idsel, bus.fbdsel, bus.odsel} !== {2'b00, 6'd3, 6'd20, 6'd56}) begin
      failures++;
      $display("FAIL pwr_locked_outs got=%b%b %0d/%0d/%0d exp=00 3/20/56",
               bus.pix_rst, bus.busy, bus.idsel, bus.fbdsel, bus.odsel);
    end
  endtask

  task automatic test_glitchy_lock();
    int n, spurious;
    bus.pll_lock = 1'b0;
    request(3'd0);
    n = 0;
    while (bus.pll_reset === 1'b1 && n < 50) begin step(); n++; end
    spurious = 0;
    bus.pll_lock = 1'b1;
    repeat (10) begin step(); if (bus.locked !== 1'b0) spurious++; end
    bus.pll_lock = 1'b0;
    step(); if (bus.locked !== 1'b0) spurious++;
    bus.pll_lock = 1'b1;
    n = 0;
    while (bus.locked !== 1'b1 && n < 100) begin step(); n++; end
    checks++;
    if (spurious != 0) begin
      failures++; $display("FAIL glitch_spurious got=%0d exp=0", spurious);
    end
    checks++;
    if (n != 2 + LOCK_FILTER) begin
      failures++; $display("FAIL glitch_lock_latency got=%0d exp=%0d", n, 2 + LOCK_FILTER);
    end
  endtask

  task automatic test_loss_of_lock();
    int n;
    bus.pll_lock = 1'b0;
    step(); n = 1;
    bus.pll_lock = 1'b1;
    while (bus.locked === 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (n != 3) begin
      failures++; $display("FAIL loss_latency got=%0d exp=3", n);
    end
    checks++;
    if ({bus.pix_rst, bus.pll_reset, bus.busy, bus.mode_cur} !== {3'b111, 3'd0}) begin
      failures++;
      $display("FAIL loss_outs got=%b%b%b mode=%0d exp=111 mode=0",
               bus.pix_rst, bus.pll_reset, bus.busy, bus.mode_cur);
    end
    n = 0;
    while (bus.locked !== 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (bus.locked !== 1'b1) begin
      failures++; $display("FAIL loss_relock got=%b exp=1", bus.locked);
    end
  endtask

  // Entered from LOCKED, so this also confirms that the earlier loss of lock
  // did not consume a retry: a full MAX_RETRIES attempts must run.
  task automatic test_timeout_fault();
    int n, pulses, len, bad_len;
    logic prev;
    bus.pll_lock = 1'b0;
    n = 0; pulses = 0; len = 0; bad_len = 0; prev = bus.pll_reset;
    while (bus.fault !== 1'b1 && n < 2000) begin
      step(); n++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL tmo_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      if (bus.pll_reset === 1'b1) len++;
      else if (prev === 1'b1) begin
        pulses++;
        if (len != RESET_PULSE) bad_len++;
        len = 0;
      end
      prev = bus.pll_reset;
    end
    checks++;
    if (n != 3 + MAX_RETRIES * (RESET_PULSE + LOCK_TIMEOUT)) begin
      failures++;
      $display("FAIL tmo_fault_time got=%0d exp=%0d", n, 3 + MAX_RETRIES * (RESET_PULSE + LOCK_TIMEOUT));
    end
    checks++;
    if (pulses != MAX_RETRIES || bad_len != 0) begin
      failures++; $display("FAIL tmo_pulses got=%0d bad_len=%0d exp=%0d bad_len=0", pulses, bad_len, MAX_RETRIES);
    end
    repeat (20) step();
    checks++;
    if ({bus.fault, bus.pll_reset, bus.busy, bus.locked, bus.pix_rst} !== 5'b11001) begin
      failures++;
      $display("FAIL tmo_fault_hold got=%b exp=11001",
               {bus.fault, bus.pll_reset, bus.busy, bus.locked, bus.pix_rst});
    end
  endtask

  task automatic test_fault_recovery();
    int n;
    bus.pll_lock = 1'b1;
    repeat (5) step();
    request(3'd1);
    checks++;
    if ({bus.fault, bus.pll_reset, bus.busy, bus.mode_cur} !== {3'b011, 3'd1}) begin
      failures++;
      $display("FAIL rec_flags got=%b%b%b mode=%0d exp=011 mode=1",
               bus.fault, bus.pll_reset, bus.busy, bus.mode_cur);
    end
    checks++;
    if ({bus.idsel, bus.fbdsel, bus.odsel} !== {6'd5, 6'd41, 6'd60}) begin
      failures++;
      $display("FAIL rec_div got=%0d/%0d/%0d exp=5/41/60", bus.idsel, bus.fbdsel, bus.odsel);
    end
    n = 1;
    while (bus.locked !== 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (n != 1 + RESET_PULSE + LOCK_FILTER) begin
      failures++; $display("FAIL rec_lock_latency got=%0d exp=%0d", n, 1 + RESET_PULSE + LOCK_FILTER);
    end
  endtask

  task automatic test_bad_request();
    for (int k = 0; k < 6; k++) begin
      logic [2:0] sel;
      sel = 3'($urandom_range(7, NUM_MODES));
      request(sel);
      checks++;
      if ({bus.req_err, bus.locked, bus.pll_reset, bus.mode_cur} !== {3'b110, 3'd1}) begin
        failures++;
        $display("FAIL badreq_pulse sel=%0d got=%b%b%b mode=%0d exp=110 mode=1",
                 sel, bus.req_err, bus.locked, bus.pll_reset, bus.mode_cur);
      end
      step();
      checks++;
      if ({bus.req_err, bus.locked} !== 2'b01) begin
        failures++; $display("FAIL badreq_single got=%b%b exp=01", bus.req_err, bus.locked);
      end
    end
  endtask

  task automatic test_abort();
    int n;
    bus.pll_lock = 1'b0;
    request(3'd0);
    n = 0;
    while (bus.pll_reset === 1'b1 && n < 50) begin step(); n++; end
    repeat ($urandom_range(40, 1)) step();
    checks++;
    if ({bus.pll_reset, bus.busy, bus.mode_cur} !== {2'b01, 3'd0}) begin
      failures++; $display("FAIL abort_in_wait got=%b%b mode=%0d exp=01 mode=0", bus.pll_reset, bus.busy, bus.mode_cur);
    end
    request(3'd1);
    checks++;
    if ({bus.pll_reset, bus.busy, bus.fault, bus.mode_cur, bus.idsel, bus.fbdsel, bus.odsel}
        !== {3'b110, 3'd1, 6'd5, 6'd41, 6'd60}) begin
      failures++;
      $display("FAIL abort_restart got=%b%b%b mode=%0d div=%0d/%0d/%0d exp=110 mode=1 div=5/41/60",
               bus.pll_reset, bus.busy, bus.fault, bus.mode_cur, bus.idsel, bus.fbdsel, bus.odsel);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    repeat (4000) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL rand_model t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec());
      end
      if (hold == 0) begin
        bus.pll_lock = ($urandom_range(3) != 0);
        hold = $urandom_range(40, 1);
      end else hold--;
      bus.mode_req = ($urandom_range(79) == 0);
      bus.mode_sel = 3'($urandom_range(7));
      rst = ($urandom_range(599) == 0);
    end
    rst = 1'b0; bus.mode_req = 1'b0;
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    bus.mode_sel = 3'd0; bus.mode_req = 1'b0; bus.pll_lock = 1'b0;
    test_reset();
    test_power_up();
    test_glitchy_lock();
    test_loss_of_lock();
    test_timeout_fault();
    test_fault_recovery();
    test_bad_request();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
